// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parameterised serial pattern detector.
// Vectors are handled at a fixed 32-bit width so one mask helper serves any MAX_LEN up to 32.
package seq_det_pkg;

    localparam int unsigned     VEC_W       = 32;
    localparam logic [VEC_W-1:0] DEF_PATTERN = 32'b0000_1001;
    localparam int unsigned     DEF_LEN     = 4;
    localparam bit              DEF_OVERLAP = 1'b1;

    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic logic [VEC_W-1:0] mask_low(input logic [VEC_W-1:0] vec,
                                                  input int unsigned len);
        logic [VEC_W-1:0] m;
        for (int unsigned i = 0; i < VEC_W; i++) begin
            m[i] = (i < len);
        end
        return vec & m;
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; a clear coinciding with an increment restarts the count at one.
module seq_match_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign sat   = (count_q == '1);

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime pattern, length and overlap mode.
// Emits a registered one-cycle match pulse and keeps a saturating match count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned        MAX_LEN         = 8,
    parameter int unsigned        CNT_W           = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int unsigned        DEFAULT_LEN     = DEF_LEN,
    parameter bit                 DEFAULT_OVERLAP = DEF_OVERLAP,
    localparam int unsigned       LEN_W           = len_width(MAX_LEN)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               data_valid,
    input  logic               data_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               data_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat,
    output logic               cfg_err
);

    // The oldest history bit would only ever be shifted out, so the register keeps
    // MAX_LEN-1 bits and the incoming bit completes the MAX_LEN-wide window.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [MAX_LEN-1:0] window;
    logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d;
    logic [LEN_W:0]     fill_next;
    logic               overlap_q, overlap_d;
    logic               data_out_q, data_out_d;
    logic               cfg_err_q, cfg_err_d;
    logic               cfg_ok, accept, full, match;

    always_comb begin
        cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        accept    = data_valid && !(cfg_load && cfg_ok);
        window    = {hist_q, data_in};
        fill_next = {1'b0, fill_q} + (LEN_W+1)'(1);
        full      = (fill_next >= {1'b0, len_q});
        match     = accept && full &&
                    (mask_low(32'(window), 32'(len_q)) == mask_low(32'(pattern_q), 32'(len_q)));

        hist_d     = hist_q;
        fill_d     = fill_q;
        pattern_d  = pattern_q;
        len_d      = len_q;
        overlap_d  = overlap_q;
        data_out_d = match;
        cfg_err_d  = cfg_load && !cfg_ok;

        if (cfg_load && cfg_ok) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (accept) begin
            hist_d = window[MAX_LEN-2:0];
            if (match && !overlap_q) begin
                fill_d = '0;
            end else if (fill_next <= {1'b0, len_q}) begin
                fill_d = fill_next[LEN_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q     <= '0;
            fill_q     <= '0;
            pattern_q  <= DEFAULT_PATTERN;
            len_q      <= LEN_W'(DEFAULT_LEN);
            overlap_q  <= DEFAULT_OVERLAP;
            data_out_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            pattern_q  <= pattern_d;
            len_q      <= len_d;
            overlap_q  <= overlap_d;
            data_out_q <= data_out_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .inc   (match),
        .clr   (count_clr),
        .count (match_count),
        .sat   (count_sat)
    );

    assign data_out = data_out_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a default-configured instance plus a
// 3-bit-counter, len=1 instance for saturation.
module tb_seq_detector_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       a_reset, a_valid, a_din, a_load, a_ovl, a_clr;
    logic [7:0] a_pat;
    logic [3:0] a_len;
    logic       a_out, a_sat, a_err;
    logic [7:0] a_cnt;

    logic       b_reset, b_valid, b_din, b_load, b_ovl, b_clr;
    logic [7:0] b_pat;
    logic [3:0] b_len;
    logic       b_out, b_sat, b_err;
    logic [2:0] b_cnt;

    int tests  = 0;
    int failed = 0;

    seq_detector_param dut_a (
        .clock       (clock),
        .reset       (a_reset),
        .data_valid  (a_valid),
        .data_in     (a_din),
        .cfg_load    (a_load),
        .cfg_pattern (a_pat),
        .cfg_len     (a_len),
        .cfg_overlap (a_ovl),
        .count_clr   (a_clr),
        .data_out    (a_out),
        .match_count (a_cnt),
        .count_sat   (a_sat),
        .cfg_err     (a_err)
    );

    seq_detector_param #(
        .CNT_W           (3),
        .DEFAULT_PATTERN (8'b0000_0001),
        .DEFAULT_LEN     (1)
    ) dut_b (
        .clock       (clock),
        .reset       (b_reset),
        .data_valid  (b_valid),
        .data_in     (b_din),
        .cfg_load    (b_load),
        .cfg_pattern (b_pat),
        .cfg_len     (b_len),
        .cfg_overlap (b_ovl),
        .count_clr   (b_clr),
        .data_out    (b_out),
        .match_count (b_cnt),
        .count_sat   (b_sat),
        .cfg_err     (b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_bit(input logic v, input logic d, input logic exp_out, input string tag);
        a_valid = v;
        a_din   = d;
        tick();
        a_valid = 1'b0;
        chk(tag, a_out, exp_out);
    endtask

    // bits are sent MSB first; exp[i] is the data_out expected after bits[i]
    task automatic a_seq(input logic [15:0] bits, input int n, input logic [15:0] exp,
                         input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            a_bit(1'b1, bits[i], exp[i], tag);
        end
    endtask

    task automatic a_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                         input logic v, input logic d);
        a_load  = 1'b1;
        a_pat   = pat;
        a_len   = len;
        a_ovl   = ovl;
        a_valid = v;
        a_din   = d;
        tick();
        a_load  = 1'b0;
        a_valid = 1'b0;
    endtask

    task automatic a_rst();
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
    endtask

    initial begin
        a_reset = 1'b1; a_valid = 1'b0; a_din = 1'b0; a_load = 1'b0;
        a_ovl = 1'b0; a_clr = 1'b0; a_pat = '0; a_len = '0;
        b_reset = 1'b1; b_valid = 1'b0; b_din = 1'b0; b_load = 1'b0;
        b_ovl = 1'b0; b_clr = 1'b0; b_pat = '0; b_len = '0;
        tick();
        tick();
        a_reset = 1'b0;
        b_reset = 1'b0;

        chk("rst_out", a_out, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_sat", a_sat, 0);
        chk("rst_err", a_err, 0);
        chk("rst_b_cnt", b_cnt, 0);

        // default pattern 1001
        a_seq(16'b1001, 4, 16'b0001, "basic");
        chk("basic_cnt", a_cnt, 1);
        a_bit(1'b0, 1'b0, 1'b0, "basic_idle");

        // overlapping
        a_rst();
        chk("ovl_rst_cnt", a_cnt, 0);
        a_seq(16'b1001001, 7, 16'b0001001, "ovl");
        chk("ovl_cnt", a_cnt, 2);

        // non-overlapping
        a_cfg(8'b0000_1001, 4'd4, 1'b0, 1'b0, 1'b0);
        chk("novl_cfg_err", a_err, 0);
        chk("novl_cfg_out", a_out, 0);
        chk("novl_cfg_cnt", a_cnt, 2);
        a_seq(16'b1001001, 7, 16'b0001000, "novl");
        chk("novl_cnt", a_cnt, 3);

        // gaps between every bit
        a_cfg(8'b0000_1001, 4'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            for (int g = 0; g < 3; g++) a_bit(1'b0, 1'b1, 1'b0, "gap_idle");
            a_bit(1'b1, 4'b1001 >> i, (i == 0), "gap_bit");
        end
        a_bit(1'b0, 1'b1, 1'b0, "gap_after");
        chk("gap_cnt", a_cnt, 4);

        // 8-bit pattern; bit in the load cycle is discarded
        a_cfg(8'b1011_0011, 4'd8, 1'b1, 1'b1, 1'b1);
        chk("len8_load_out", a_out, 0);
        chk("len8_load_err", a_err, 0);
        a_seq(16'b1011_0011, 8, 16'b0000_0001, "len8");
        chk("len8_cnt", a_cnt, 5);

        // rejected cfg_len=0; same-cycle bit 1 is the first bit of the next match
        a_load = 1'b1; a_pat = 8'hFF; a_len = 4'd0; a_ovl = 1'b0;
        a_valid = 1'b1; a_din = 1'b1;
        tick();
        a_load = 1'b0; a_valid = 1'b0;
        chk("bad0_err", a_err, 1);
        chk("bad0_out", a_out, 0);
        a_seq(16'b011_0011, 7, 16'b000_0001, "bad0");
        chk("bad0_err_clr", a_err, 0);
        chk("bad0_cnt", a_cnt, 6);

        // rejected cfg_len=9
        a_load = 1'b1; a_pat = 8'h00; a_len = 4'd9; a_ovl = 1'b0;
        a_valid = 1'b1; a_din = 1'b1;
        tick();
        a_load = 1'b0; a_valid = 1'b0;
        chk("bad9_err", a_err, 1);
        a_seq(16'b011_0011, 7, 16'b000_0001, "bad9");
        chk("bad9_cnt", a_cnt, 7);

        // count_clr alone
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("clr_cnt", a_cnt, 0);

        // len=1, non-overlapping
        a_cfg(8'b1111_1101, 4'd1, 1'b0, 1'b0, 1'b0);
        a_seq(16'b1101, 4, 16'b1101, "len1");
        chk("len1_cnt", a_cnt, 3);

        // reset mid-stream wins over a same-cycle completing bit
        a_rst();
        a_seq(16'b100, 3, 16'b000, "mid_pre");
        a_reset = 1'b1; a_valid = 1'b1; a_din = 1'b1;
        tick();
        a_reset = 1'b0; a_valid = 1'b0;
        chk("mid_rst_out", a_out, 0);
        chk("mid_rst_cnt", a_cnt, 0);
        a_bit(1'b1, 1'b1, 1'b0, "mid_post");
        a_seq(16'b1001, 4, 16'b0001, "mid_full");
        chk("mid_cnt", a_cnt, 1);

        // saturation on the 3-bit counter instance
        for (int i = 1; i <= 10; i++) begin
            b_valid = 1'b1; b_din = 1'b1;
            tick();
            chk("sat_out", b_out, 1);
            chk("sat_cnt", b_cnt, (i >= 7) ? 7 : i);
            chk("sat_flag", b_sat, (i >= 7));
        end
        b_din = 1'b0;
        tick();
        chk("sat_zero_out", b_out, 0);
        chk("sat_hold_cnt", b_cnt, 7);
        b_din = 1'b1; b_clr = 1'b1;
        tick();
        chk("clr_match_cnt", b_cnt, 1);
        chk("clr_match_sat", b_sat, 0);
        b_valid = 1'b0;
        tick();
        b_clr = 1'b0;
        chk("clr_only_cnt", b_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
